// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC sequencing, imem word reads, ordered response buffering, redirect flush.
// Latency: imem_rvalid in cycle N gives out_valid in cycle N+1 (registered buffer, no bypass).
// Backpressure: requests issue only while outstanding+buffered < BUF_DEPTH, so every response has a slot.
//
// Ports: clk_i/rst_ni (async active-low reset), imem_req_o/imem_addr_o (request, no grant),
//        imem_rvalid_i/imem_rdata_i (in-order responses), redirect_en_i/redirect_pc_i (taken branch),
//        out_valid_o/out_ready_i/out_packet_o (fetch packet {pc[14:0], instr, 10'b0}),
//        stall_cycles_o/empty_cycles_o (perf counters).
// Optional feature macro: FETCH_PERF_CNT_EN (counters present; otherwise driven to 0).
module fetch_unit #(
    parameter logic [15:0] BOOT_PC   = 16'h0000,
    parameter int          BUF_DEPTH = 2,
    parameter int          CNT_W     = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    output logic             imem_req_o,
    output logic [15:0]      imem_addr_o,
    input  logic             imem_rvalid_i,
    input  logic [15:0]      imem_rdata_i,
    input  logic             redirect_en_i,
    input  logic [15:0]      redirect_pc_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [40:0]      out_packet_o,
    output logic [CNT_W-1:0] stall_cycles_o,
    output logic [CNT_W-1:0] empty_cycles_o
);

    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {S_BOOT, S_RUN, S_DRAIN} state_e;

    state_e          state_q, state_d;
    logic [15:0]     pc_q, pc_d;
    logic [CW-1:0]   outst_q, outst_d;
    logic [CW-1:0]   kill_q, kill_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   rd_q, rd_d, wr_q, wr_d;
    logic [PW-1:0]   trd_q, trd_d, twr_q, twr_d;
    logic [30:0]     buf_q [BUF_DEPTH];   // {pc[14:0], instr[15:0]}
    logic [14:0]     tag_q [BUF_DEPTH];   // pc of each in-flight request, oldest at trd_q

    logic            rsp, redir, issue, push, pop;
    logic [CW:0]     inflight;

    always_comb begin
        // A response with nothing outstanding is a protocol error and is ignored.
        rsp      = imem_rvalid_i && (outst_q != '0);
        redir    = redirect_en_i && (state_q != S_BOOT);
        inflight = {1'b0, outst_q} + {1'b0, cnt_q};
        issue    = (state_q == S_RUN) && !redirect_en_i && (inflight < (CW+1)'(BUF_DEPTH));
        push     = rsp && (kill_q == '0) && !redir;
        pop      = (cnt_q != '0) && out_ready_i && !redir;

        state_d  = state_q;
        pc_d     = pc_q;
        outst_d  = outst_q + CW'(issue) - CW'(rsp);
        kill_d   = kill_q;
        cnt_d    = cnt_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        // Tag FIFO tracks every in-flight request, killed or not, so it stays aligned with responses.
        twr_d    = twr_q + PW'(issue);
        trd_d    = trd_q + PW'(rsp);

        if (redir) begin
            // Everything still in flight belongs to the wrong path.
            kill_d = outst_q - CW'(rsp);
            pc_d   = redirect_pc_i;
            cnt_d  = '0;
            rd_d   = '0;
            wr_d   = '0;
        end else begin
            if (rsp && (kill_q != '0)) kill_d = kill_q - 1'b1;
            if (issue) pc_d = pc_q + 16'd1;
            rd_d  = rd_q + PW'(pop);
            wr_d  = wr_q + PW'(push);
            cnt_d = cnt_q + CW'(push) - CW'(pop);
        end

        case (state_q)
            S_BOOT:  state_d = S_RUN;
            S_RUN,
            S_DRAIN: state_d = (kill_d != '0) ? S_DRAIN : S_RUN;
            default: state_d = S_BOOT;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_BOOT;
            pc_q    <= BOOT_PC;
            outst_q <= '0;
            kill_q  <= '0;
            cnt_q   <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            trd_q   <= '0;
            twr_q   <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_q[i] <= '0;
                tag_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            outst_q <= outst_d;
            kill_q  <= kill_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            trd_q   <= trd_d;
            twr_q   <= twr_d;
            if (issue) tag_q[twr_q] <= pc_q[14:0];
            if (push)  buf_q[wr_q]  <= {tag_q[trd_q], imem_rdata_i};
        end
    end

    assign imem_req_o   = issue;
    assign imem_addr_o  = pc_q;
    assign out_valid_o  = (cnt_q != '0);
    assign out_packet_o = out_valid_o ? {buf_q[rd_q], 10'b0} : '0;

`ifdef FETCH_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q, empty_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_q <= '0;
            empty_q <= '0;
        end else begin
            if (out_valid_o && !out_ready_i && (stall_q != '1))
                stall_q <= stall_q + 1'b1;
            if ((state_q == S_RUN) && !out_valid_o && (empty_q != '1))
                empty_q <= empty_q + 1'b1;
        end
    end

    assign stall_cycles_o = stall_q;
    assign empty_cycles_o = empty_q;
`else
    assign stall_cycles_o = '0;
    assign empty_cycles_o = '0;
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (rst_ni && imem_rvalid_i && (outst_q == '0))
            $error("fetch_unit: imem_rvalid with no outstanding request");
    end
`endif

endmodule
